oflow_score_calc_min_unit: RTL and testbench

//  Responder side of the score_calc start_calc_min/done_calc_min handshake. On each start pulse,

---
 rtl/oflow_score_calc_min_unit.sv | 130 +++++++++++++
 tb/tb_oflow_score_calc_min_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/oflow_score_calc_min_unit.sv
// Running-minimum scanner for score_calc: latches a batch of similarity scores on
// start_calc_min, scans one per cycle and tracks the lowest valid score and its object ID.
module oflow_score_calc_min_unit #(
  parameter int SCORE_W    = 16,
  parameter int ID_W       = 12,
  parameter int NUM_SCORES = 8
) (
  input  logic                          clk,
  input  logic                          reset_N,
  input  logic                          start_calc_min,
  input  logic                          init_min,
  input  logic [NUM_SCORES*SCORE_W-1:0] scores_in,
  input  logic [NUM_SCORES-1:0]         score_valid,
  input  logic [ID_W-1:0]               base_id,
  output logic                          done_calc_min,
  output logic                          busy,
  output logic [SCORE_W-1:0]            min_score,
  output logic [ID_W-1:0]               min_id,
  output logic                          min_found
);

  localparam int IDX_W = $clog2(NUM_SCORES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SCORE_W-1:0]    r_scores [NUM_SCORES];
  logic [NUM_SCORES-1:0] r_valid;
  logic [ID_W-1:0]       r_base_id;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_done;
  logic [SCORE_W-1:0]    r_min_score;
  logic [ID_W-1:0]       r_min_id;
  logic                  r_min_found;

  logic                  w_latch;
  logic                  w_clear;
  logic                  w_update;
  logic                  w_last;
  logic [SCORE_W-1:0]    w_cur_score;
  logic [ID_W-1:0]       w_cur_id;

  assign w_cur_score = r_scores[r_idx];
  assign w_cur_id    = r_base_id + ID_W'(r_idx);
  assign w_last      = (r_idx == IDX_W'(NUM_SCORES - 1));

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_clear     = 1'b0;
    w_update    = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clear = init_min;
        if (start_calc_min) begin
          w_latch     = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        // Strict compare keeps the earliest entry on ties, across batches too.
        w_update = r_valid[r_idx] && (!r_min_found || (w_cur_score < r_min_score));
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int unsigned i = 0; i < NUM_SCORES; i++) r_scores[i] <= '0;
      r_valid   <= '0;
      r_base_id <= '0;
      r_idx     <= '0;
    end else if (w_latch) begin
      for (int unsigned i = 0; i < NUM_SCORES; i++) r_scores[i] <= scores_in[i*SCORE_W +: SCORE_W];
      r_valid   <= score_valid;
      r_base_id <= base_id;
      r_idx     <= '0;
    end else if (r_state == SCAN) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_min_score <= '1;
      r_min_id    <= '0;
      r_min_found <= 1'b0;
    end else if (w_clear) begin
      r_min_score <= '1;
      r_min_id    <= '0;
      r_min_found <= 1'b0;
    end else if (w_update) begin
      r_min_score <= w_cur_score;
      r_min_id    <= w_cur_id;
      r_min_found <= 1'b1;
    end
  end

  // Done is registered off the DONE state, so it lands one cycle after DONE itself.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) r_done <= 1'b0;
    else          r_done <= (r_state == DONE);
  end

  assign done_calc_min = r_done;
  assign min_score     = r_min_score;
  assign min_id        = r_min_id;
  assign min_found     = r_min_found;

endmodule

// File: tb/tb_oflow_score_calc_min_unit.sv
// Self-checking bench for oflow_score_calc_min_unit: directed and random batches
// against a set-level model of the running minimum.
module tb_oflow_score_calc_min_unit;

  localparam int SW = 16;
  localparam int IW = 12;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            reset_N = 1'b0;
  logic            start_calc_min = 1'b0;
  logic            init_min = 1'b0;
  logic [N*SW-1:0] scores_in = '0;
  logic [N-1:0]    score_valid = '0;
  logic [IW-1:0]   base_id = '0;
  logic            done_calc_min;
  logic            busy;
  logic [SW-1:0]   min_score;
  logic [IW-1:0]   min_id;
  logic            min_found;

  oflow_score_calc_min_unit #(.SCORE_W(SW), .ID_W(IW), .NUM_SCORES(N)) dut (
    .clk(clk), .reset_N(reset_N), .start_calc_min(start_calc_min), .init_min(init_min),
    .scores_in(scores_in), .score_valid(score_valid), .base_id(base_id),
    .done_calc_min(done_calc_min), .busy(busy), .min_score(min_score),
    .min_id(min_id), .min_found(min_found)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [SW-1:0] t_sc [N];
  logic [N-1:0]  t_val;
  logic [IW-1:0] t_base;

  logic [SW-1:0] m_score = '1;
  logic [IW-1:0] m_id    = '0;
  logic          m_found = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_score = '1;
    m_id    = '0;
    m_found = 1'b0;
  endtask

  // Best of the batch = smallest valid score, lowest index on ties; it replaces the
  // running minimum only if strictly smaller (or nothing found yet).
  task automatic model_batch(input bit init);
    int best;
    if (init) model_clear();
    best = -1;
    for (int i = 0; i < N; i++)
      if (t_val[i] && (best < 0 || t_sc[i] < t_sc[best])) best = i;
    if (best >= 0 && (!m_found || t_sc[best] < m_score)) begin
      m_score = t_sc[best];
      m_id    = t_base + IW'(best);
      m_found = 1'b1;
    end
  endtask

  task automatic drive_batch();
    for (int i = 0; i < N; i++) scores_in[i*SW +: SW] = t_sc[i];
    score_valid = t_val;
    base_id     = t_base;
  endtask

  task automatic chk_min(input string tag);
    chk({tag, ".score"}, 32'(min_score), 32'(m_score));
    chk({tag, ".id"},    32'(min_id),    32'(m_id));
    chk({tag, ".found"}, 32'(min_found), 32'(m_found));
  endtask

  // Caller is at a negedge. Returns at the negedge where done should be high.
  task automatic run_batch(input string tag, input bit init, input bit poke);
    int nb, nd, dpos;
    start_calc_min = 1'b1;
    init_min       = init;
    drive_batch();
    model_batch(init);
    @(negedge clk);
    start_calc_min = 1'b0;
    init_min       = 1'b0;
    nb = 0; nd = 0; dpos = -1;
    for (int j = 0; j <= 9; j++) begin
      if (j > 0) @(negedge clk);
      nb += int'(busy);
      if (done_calc_min) begin nd++; dpos = j; end
      if (poke && j == 3) begin
        start_calc_min = 1'b1;
        init_min       = 1'b1;
        scores_in      = '0;
        score_valid    = '1;
      end
      if (poke && j == 4) begin
        start_calc_min = 1'b0;
        init_min       = 1'b0;
      end
    end
    chk({tag, ".busy_cycles"}, 32'(nb), 32'(N));
    chk({tag, ".done_count"},  32'(nd), 32'd1);
    chk({tag, ".done_pos"},    32'(dpos), 32'(N + 1));
    chk_min(tag);
  endtask

  task automatic chk_quiet(input string tag, input int cycles);
    int nd, nb;
    nd = 0; nb = 0;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      nd += int'(done_calc_min);
      nb += int'(busy);
    end
    chk({tag, ".no_done"}, 32'(nd), 32'd0);
    chk({tag, ".no_busy"}, 32'(nb), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) t_sc[i] = '0;
    t_val = '0; t_base = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst.done", 32'(done_calc_min), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk_min("rst");
    reset_N = 1'b1;
    @(negedge clk);

    // Basic batch
    t_sc = '{16'd50, 16'd30, 16'd70, 16'd30, 16'd90, 16'd10, 16'd60, 16'd20};
    t_val = '1; t_base = 12'd100;
    run_batch("t1", 1'b1, 1'b0);
    chk("t1.score_const", 32'(min_score), 32'd10);
    chk("t1.id_const",    32'(min_id),    32'd105);

    // Running minimum, back-to-back starts
    for (int i = 0; i < N; i++) t_sc[i] = 16'd40;
    t_base = 12'd200;
    run_batch("t2a", 1'b0, 1'b0);
    t_sc[2] = 16'd5; t_base = 12'd300;
    run_batch("t2b", 1'b0, 1'b0);
    chk("t2b.id_const", 32'(min_id), 32'd302);

    // Ties with mask, then an all-invalid batch with init
    t_sc = '{16'd7, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
    t_val = 8'b1111_1101; t_base = 12'd50;
    run_batch("t3a", 1'b1, 1'b0);
    t_val = '0;
    run_batch("t3b", 1'b1, 1'b0);

    // Starts/inits during SCAN are ignored
    for (int i = 0; i < N; i++) t_sc[i] = SW'(20 + i);
    t_val = '1; t_base = 12'd10;
    run_batch("t4a", 1'b0, 1'b1);
    chk_quiet("t4a", 4);

    // init_min alone in IDLE clears
    init_min = 1'b1;
    @(negedge clk);
    init_min = 1'b0;
    model_clear();
    chk_min("t4b");

    // Reset mid-scan
    t_sc[4] = 16'd1;
    start_calc_min = 1'b1;
    drive_batch();
    @(negedge clk);
    start_calc_min = 1'b0;
    repeat (4) @(negedge clk);
    reset_N = 1'b0;
    #1;
    model_clear();
    chk("t5.busy", 32'(busy), 32'd0);
    chk("t5.done", 32'(done_calc_min), 32'd0);
    chk_min("t5");
    chk_quiet("t5.inreset", 12);
    reset_N = 1'b1;
    chk_quiet("t5.after", 3);

    // ID wrap
    for (int i = 0; i < N; i++) t_sc[i] = 16'd100;
    t_sc[3] = 16'd9; t_val = '1; t_base = 12'd4094;
    run_batch("t5w", 1'b1, 1'b0);
    chk("t5w.id_const", 32'(min_id), 32'd1);

    // Random batches, including all-ones scores and empty masks
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < N; i++)
        t_sc[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : SW'($urandom_range(0, 15));
      t_val  = ($urandom_range(0, 7) == 0) ? 8'h00 : N'($urandom);
      t_base = IW'($urandom);
      run_batch("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) chk_quiet("rnd", $urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
